// File: rtl/branch_pkg.sv
// Shared definitions for the pipelined branch-resolution unit:
// funct3 encodings, per-stage payload layouts and the combine/decode helpers.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Payload leaving the compare stage. The tag rides alongside this struct
    // as a separate field because its width is a module parameter.
    typedef struct packed {
        logic       eq_hi;
        logic       lt_hi;
        logic       eq_lo;
        logic       lt_lo;
        logic [2:0] funct3;
        logic       pred_taken;
    } partial_t;

    // Payload leaving the combine/decode stage.
    typedef struct packed {
        logic br_eq;
        logic br_lt;
        logic taken;
        logic mispredict;
        logic illegal;
    } result_t;

    localparam int PART_W  = $bits(partial_t);
    localparam int RES_W   = $bits(result_t);
    // Every slice carries the wider of the two layouts; results are zero-padded.
    localparam int PAYLOAD_W = (PART_W > RES_W) ? PART_W : RES_W;

    function automatic logic decode_taken(input logic [2:0] funct3,
                                          input logic eq, input logic lt);
        logic t;
        case (funct3)
            F3_BEQ:          t = eq;
            F3_BNE:          t = !eq;
            F3_BLT, F3_BLTU: t = lt;
            F3_BGE, F3_BGEU: t = !lt;
            default:         t = 1'b0;
        endcase
        return t;
    endfunction

    // Merge the half-width flags into full-width flags and decode the outcome.
    function automatic result_t combine(input partial_t p);
        result_t r;
        logic    eq;
        logic    lt;
        logic    ill;
        eq  = p.eq_hi & p.eq_lo;
        lt  = p.lt_hi | (p.eq_hi & p.lt_lo);
        ill = (p.funct3[2:1] == 2'b01);
        r.br_eq      = eq;
        r.br_lt      = lt;
        r.taken      = decode_taken(p.funct3, eq, lt);
        r.illegal    = ill;
        r.mispredict = !ill && (r.taken != p.pred_taken);
        return r;
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// Generic valid/ready register slice. A held entry is released only when the
// downstream accepts, so the output is stable while stalled; flush kills the
// entry at the next edge and drops anything offered in the same cycle.
module pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Next-state: load on transfer, empty when the held entry leaves, clear on flush.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/branch_resolve_pipe.sv
// Pipelined branch resolution: split half-width compare, funct3 decode,
// valid/ready handshake with flush, and saturating branch/mispredict counters.
// Legal builds: DWIDTH even and >= 4, STAGES in 1..4.
module branch_resolve_pipe
    import branch_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic [2:0]        funct3,
    input  logic              pred_taken,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    input  logic              clear_stats,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              br_eq,
    output logic              br_lt,
    output logic              taken,
    output logic              mispredict,
    output logic              illegal,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int H       = DWIDTH / 2;
    localparam int SW      = PAYLOAD_W + TAG_W;
    localparam int RES_PAD = PAYLOAD_W - RES_W;

    // Index 0 is the upstream port; index s is the output of slice s.
    logic [STAGES:0] stg_valid;
    logic [STAGES:0] stg_ready;
    logic [SW-1:0]   stg_din  [1:STAGES];
    logic [SW-1:0]   stg_dout [1:STAGES];

    partial_t in_part;
    result_t  out_res;

    assign stg_valid[0]      = in_valid;
    assign in_ready          = stg_ready[0];
    assign stg_ready[STAGES] = out_ready;

    // Half-width compares: low halves unsigned, high halves signed unless funct3[1].
    always_comb begin
        in_part.eq_hi      = (a[DWIDTH-1:H] == b[DWIDTH-1:H]);
        in_part.lt_hi      = funct3[1] ? (a[DWIDTH-1:H] < b[DWIDTH-1:H])
                                       : ($signed(a[DWIDTH-1:H]) < $signed(b[DWIDTH-1:H]));
        in_part.eq_lo      = (a[H-1:0] == b[H-1:0]);
        in_part.lt_lo      = (a[H-1:0] < b[H-1:0]);
        in_part.funct3     = funct3;
        in_part.pred_taken = pred_taken;
    end

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        if (s == 1) begin : g_first
            if (STAGES == 1) begin : g_single
                // Compare and combine share the only cycle.
                assign stg_din[s] = {{RES_PAD{1'b0}}, combine(in_part), in_tag};
            end else begin : g_split
                assign stg_din[s] = {in_part, in_tag};
            end
        end else if (s == 2) begin : g_combine
            partial_t p;
            assign p          = partial_t'(stg_dout[1][SW-1:TAG_W]);
            assign stg_din[s] = {{RES_PAD{1'b0}}, combine(p), stg_dout[1][TAG_W-1:0]};
        end else begin : g_delay
            assign stg_din[s] = stg_dout[s-1];
        end

        pipe_slice #(.W(SW)) u_slice (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (flush),
            .in_valid_i  (stg_valid[s-1]),
            .in_ready_o  (stg_ready[s-1]),
            .in_data_i   (stg_din[s]),
            .out_valid_o (stg_valid[s]),
            .out_ready_i (stg_ready[s]),
            .out_data_o  (stg_dout[s])
        );
    end

    assign out_res    = result_t'(stg_dout[STAGES][TAG_W +: RES_W]);
    assign out_valid  = stg_valid[STAGES];
    assign br_eq      = out_res.br_eq;
    assign br_lt      = out_res.br_lt;
    assign taken      = out_res.taken;
    assign mispredict = out_res.mispredict;
    assign illegal    = out_res.illegal;
    assign out_tag    = stg_dout[STAGES][TAG_W-1:0];

    logic unused_pad;
    assign unused_pad = ^stg_dout[STAGES][SW-1:TAG_W+RES_W];

    logic             count_en;
    logic [CNT_W-1:0] br_q, br_d;
    logic [CNT_W-1:0] mis_q, mis_d;

    assign count_en      = out_valid && out_ready && !out_res.illegal;
    assign br_count      = br_q;
    assign mispred_count = mis_q;

    // Counter next-state: clear dominates, otherwise saturating increment on a legal handshake.
    always_comb begin
        br_d  = br_q;
        mis_d = mis_q;
        if (clear_stats) begin
            br_d  = '0;
            mis_d = '0;
        end else if (count_en) begin
            if (br_q != {CNT_W{1'b1}}) begin
                br_d = br_q + CNT_W'(1);
            end
            if (out_res.mispredict && (mis_q != {CNT_W{1'b1}})) begin
                mis_d = mis_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            br_q  <= br_d;
            mis_q <= mis_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Directed bench for branch_resolve_pipe (STAGES=2, CNT_W=4 build).
module tb_branch_resolve_pipe;

    localparam int DWIDTH = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = 4;
    localparam int EW     = TAG_W + 5;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic [2:0]        funct3;
    logic              pred_taken;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              clear_stats;
    logic              out_valid;
    logic              out_ready;
    logic              br_eq;
    logic              br_lt;
    logic              taken;
    logic              mispredict;
    logic              illegal;
    logic [TAG_W-1:0]  out_tag;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  mispred_count;

    branch_resolve_pipe #(
        .DWIDTH (DWIDTH),
        .STAGES (STAGES),
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .funct3        (funct3),
        .pred_taken    (pred_taken),
        .in_tag        (in_tag),
        .flush         (flush),
        .clear_stats   (clear_stats),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .br_eq         (br_eq),
        .br_lt         (br_lt),
        .taken         (taken),
        .mispredict    (mispredict),
        .illegal       (illegal),
        .out_tag       (out_tag),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int exp_br   = 0;
    int exp_mis  = 0;

    // Expected result layout: {tag, eq, lt, taken, mispredict, illegal}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic        pred;
        logic        eq;
        logic        lt;
        logic        tk;
        logic        mis;
        logic        ill;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [TAG_W-1:0] tag, input logic eq, input logic lt,
                                         input logic tk, input logic mis, input logic ill);
        return {tag, eq, lt, tk, mis, ill};
    endfunction

    // Scoreboard: a handshake happens at the next rising edge when valid&ready at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got tag %0d, expected no output at %0t", out_tag, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_result", {out_tag, br_eq, br_lt, taken, mispredict, illegal}, mon_e);
                if (!mon_e[0]) begin
                    if (exp_br < CMAX) exp_br++;
                    if (mon_e[1] && exp_mis < CMAX) exp_mis++;
                end
            end
        end
    end

    // Driver: present one branch and hold it until accepted.
    task automatic send(input logic [31:0] sa, input logic [31:0] sb, input logic [2:0] sf,
                        input logic sp, input logic [TAG_W-1:0] st);
        bit acc;
        int n;
        a = sa;
        b = sb;
        funct3 = sf;
        pred_taken = sp;
        in_tag = st;
        in_valid = 1'b1;
        acc = 0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: tag %0d not accepted, expected accept within 50 cycles", st);
        end
    endtask

    // Wait until every expected result has left, then step past the handshake edge.
    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic do_clear_stats();
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        exp_br = 0;
        exp_mis = 0;
    endtask

    task automatic check_counts(input string tagname);
        check({tagname, "_br_count"}, 64'(br_count), 64'(exp_br));
        check({tagname, "_mispred_count"}, 64'(mispred_count), 64'(exp_mis));
    endtask

    int out_base;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'hFFFF_FFFF, 32'h1,         3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h1,         3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h1,         3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'h0001_0000, 32'h0000_FFFF, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'h1,         32'h2,         3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h5,         32'h6,         3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32'h1,         32'h2,         3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h8000_0000, 32'h0,         3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h1234_5678, 32'h1234_5679, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h3,         32'h3,         3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h1,         32'h2,         3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        funct3 = '0;
        pred_taken = 1'b0;
        in_tag = '0;
        flush = 1'b0;
        clear_stats = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_flags", {br_eq, br_lt, taken, mispredict, illegal}, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check_counts("rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // BEQ 5,5 predicted not-taken: latency of two edges and first counter update
        exp_q.push_back(mk(5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        send(32'd5, 32'd5, 3'b000, 1'b0, 5'd1);
        check("lat_edge1_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_edge2_out_valid", 64'(out_valid), 64'd1);
        wait_drain();
        check("first_br_count", 64'(br_count), 64'd1);
        check("first_mispred_count", 64'(mispred_count), 64'd1);

        // Decode / split-compare table
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(mk(TAG_W'(i + 2), vecs[i].eq, vecs[i].lt, vecs[i].tk, vecs[i].mis, vecs[i].ill));
            send(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].pred, TAG_W'(i + 2));
            wait_drain();
            check_counts("vec");
        end

        do_clear_stats();
        check("clear_br_count", 64'(br_count), 64'd0);
        check("clear_mispred_count", 64'(mispred_count), 64'd0);

        // Back-to-back stream with a three-cycle output stall
        out_base = n_out;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(mk(TAG_W'(10 + i), i == 3, i < 3, i < 3, i < 3, 1'b0));
        end
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(32'(i), 32'd3, 3'b110, 1'b0, TAG_W'(10 + i));
                end
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                #1;
                check("stall_in_ready", 64'(in_ready), 64'd0);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check("stall_out_valid", 64'(out_valid), 64'd1);
                    check("stall_out_tag", 64'(out_tag), 64'd10);
                    check("stall_in_ready_hold", 64'(in_ready), 64'd0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("stream_out_count", 64'(n_out - out_base), 64'd6);
        check("stream_br_count", 64'(br_count), 64'd6);
        check("stream_mispred_count", 64'(mispred_count), 64'd3);

        // Flush with two entries in flight, an input offered in the flush cycle
        out_base = n_out;
        out_ready = 1'b0;
        send(32'd7, 32'd7, 3'b000, 1'b0, 5'd20);
        send(32'd7, 32'd8, 3'b000, 1'b0, 5'd21);
        check("preflush_out_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        in_valid = 1'b1;
        in_tag = 5'd22;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("postflush_out_valid", 64'(out_valid), 64'd0);
        end
        check("flush_out_count", 64'(n_out - out_base), 64'd0);
        check_counts("flush");

        // Saturation: 17 mispredicted branches into a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(mk(TAG_W'(i), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
            send(32'd0, 32'd0, 3'b000, 1'b0, TAG_W'(i));
        end
        wait_drain();
        check("sat_br_count", 64'(br_count), 64'hF);
        check("sat_mispred_count", 64'(mispred_count), 64'hF);

        // clear_stats coinciding with a handshake
        out_ready = 1'b0;
        exp_q.push_back(mk(5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        send(32'd1, 32'd9, 3'b100, 1'b1, 5'd7);
        @(posedge clk);
        #1;
        check("clrhs_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        exp_br = 0;
        exp_mis = 0;
        check("clrhs_br_count", 64'(br_count), 64'd0);
        check("clrhs_mispred_count", 64'(mispred_count), 64'd0);
        check("clrhs_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-stream
        out_base = n_out;
        exp_q.push_back(mk(5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        send(32'd4, 32'd4, 3'b000, 1'b1, 5'd1);
        send(32'd4, 32'd4, 3'b000, 1'b1, 5'd2);
        check("prerst_out_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_br = 0;
        exp_mis = 0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        check_counts("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("postrst_out_valid", 64'(out_valid), 64'd0);
        end
        check("postrst_out_count", 64'(n_out - out_base), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_pipe.md
# branch_resolve_pipe

Pipelined, parametrised branch-resolution unit for the pipelined SimpleRV core. It generalises the single-cycle branch comparator: it decodes the branch funct3 itself, splits the DWIDTH compare across a configurable number of register stages, and carries a valid/ready handshake with flush. It also tracks branch and mispredict statistics. It sits between the execute-stage operand muxes and the fetch redirect logic.

## Interface
- DWIDTH, 32: operand width; must be even and ≥ 4.
- STAGES, 2: pipeline depth, legal range 1..4.
- TAG_W, 5: width of the opaque tag that travels with each branch.
- CNT_W, 32: width of the statistics counters.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream branch present.
- in_ready  out  1  unit can accept this cycle.
- a, b  in  DWIDTH  rs1 / rs2 operands.
- funct3  in  3  RISC-V branch funct3.
- pred_taken  in  1  fetch-side prediction.
- in_tag  in  TAG_W  opaque tag.
- flush  in  1  kill all in-flight entries.
- clear_stats  in  1  synchronous clear of both counters.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- br_eq, br_lt  out  1  compare flags; br_lt is signed or unsigned per funct3.
- taken  out  1  branch outcome.
- mispredict  out  1  taken != pred_taken, gated by legal funct3.
- illegal  out  1  funct3 is 010 or 011.
- out_tag  out  TAG_W  tag of the result.
- br_count, mispred_count  out  CNT_W  statistics counters.

## Operation
- funct3 decode:
  - 000 BEQ: taken = eq.
  - 001 BNE: taken = !eq.
  - 100 BLT: taken = lt, signed.
  - 101 BGE: taken = !lt, signed.
  - 110 BLTU: taken = lt, unsigned.
  - 111 BGEU: taken = !lt, unsigned.
  - 010/011: illegal = 1, taken = 0, mispredict = 0.
- Split compare, with H = DWIDTH/2:
  - Low halves are always compared unsigned.
  - High halves are compared signed when funct3[1] = 0, unsigned otherwise.
  - eq = eq_hi & eq_lo.
  - lt = lt_hi | (eq_hi & lt_lo).
- Stage placement:
  - STAGES = 1: half compares and combine happen in the same cycle, then one register.
  - STAGES ≥ 2: stage 1 registers the four partial flags, funct3, pred_taken and tag. Stage 2 combines and decodes. Stages 3..STAGES are pure delay slices.
- Handshake:
  - Each stage has a valid bit; stage_ready = !valid | next_ready.
  - in_ready = stage-1 ready; the last stage's next_ready is out_ready.
  - A transfer occurs on valid & ready.
  - out_* signals stay stable while out_valid & !out_ready.
- Flush:
  - At the next edge, all stage valid bits are cleared.
  - An input presented in the flush cycle is dropped.
  - An output handshake in the flush cycle still completes and is counted.
- Counters, updated on each output handshake with !illegal:
  - br_count increments by 1.
  - mispred_count increments by 1 if mispredict.
  - Both saturate at all-ones.
  - clear_stats wins over a simultaneous increment; the result is 0.

## Timing
- Reset (async, rst_n = 0):
  - All valid bits = 0, so out_valid = 0 and in_ready = 1.
  - br_eq, br_lt, taken, mispredict, illegal = 0; out_tag = 0; both counters = 0.
- Latency: with out_ready held at 1, out_valid rises exactly STAGES cycles after the accepting edge.
- Throughput: 1 branch per cycle.
- Backpressure: a full pipe under out_ready = 0 holds all entries and deasserts in_ready in the same cycle. Bubbles ahead of a stall are absorbed, so in_ready stays 1 while any stage is empty.
- Reset mid-operation discards every entry immediately; nothing is emitted after release until new inputs arrive.
- Counter values are visible the cycle after the handshake edge.

## Structure
- branch_pkg holds:
  - funct3 localparams F3_BEQ … F3_BGEU.
  - A packed struct for per-stage payload: partial flags, funct3, pred_taken, tag.
  - A function decode_taken(funct3, eq, lt).
- One sub-module, pipe_slice: a generic valid/ready register slice parametrised by payload width. It is instantiated STAGES times via generate; stages 3..STAGES are bare slices.

## Test plan
- Reset, then a=5, b=5, BEQ, pred_taken=0, STAGES=2 → out_valid on the 2nd edge after accept; taken=1, br_eq=1, mispredict=1, br_count=1, mispred_count=1.
- a=32'hFFFFFFFF, b=1: BLT → taken=1; BLTU → taken=0; BGEU → taken=1. Exercises the split where the high halves differ in sign.
- a=32'h0001_0000, b=32'h0000_FFFF, BGE → taken=1 (high-half decides). a=32'h0000_0001, b=32'h0000_0002, BLTU → taken=1 (low-half decides).
- Stream 6 back-to-back branches, hold out_ready=0 for 3 cycles mid-stream → in_ready drops once the pipe is full; all 6 out_tags emerge in order, none duplicated; br_count=6.
- Flush asserted with 2 entries in flight → no out_valid for those entries. funct3=3'b010 input → illegal=1, taken=0, counters unchanged.
- Preload br_count to all-ones via 2^CNT_W branches (CNT_W=4 build: 16 branches) → count stays 4'hF. clear_stats asserted in the same cycle as a handshake → both counters = 0. rst_n low mid-stream → out_valid=0 immediately.
